mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data-select path between four requesters.
- Decides which requester owns the path and drives the select code.
- Grants bursts of up to MAX_BURST beats, and presents the selected data on a valid/ready output handshake toward a single consumer.
- Sits between four producer channels and one downstream sink.

Parameters:
WIDTH, 8, data width of each requester channel and of the output.
MAX_BURST, 4, maximum beats accepted per grant before the arbiter must re-arbitrate (legal range 1..16).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
req  input  4  req[i] high while requester i has a beat on its data lane; must stay high until the beat is acked or the requester aborts.
din  input  4*WIDTH  packed lanes; lane i = din[i*WIDTH +: WIDTH]; held stable while req[i] is high and unacked.
out_ready  input  1  sink can accept a beat this cycle.
out_valid  output  1  out_data carries a beat from the granted requester.
out_data  output  WIDTH  lane selected by sel.
ack  output  4  one-hot pulse; ack[i] high in the cycle requester i's beat is accepted.
grant  output  4  registered one-hot owner of the path; 0 when idle.
sel  output  2  registered select code (encoded grant) driving the 4:1 path.
busy  output  1  high in BUSY state.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (clk edge with rst=1):
  - state=IDLE, grant=4'b0000, sel=2'b00, priority pointer ptr=0, beat counter cnt=0.
  - out_valid=0, ack=0, busy=0.
  - Reset mid-burst abandons the burst; no ack is issued in the reset cycle.
- States: IDLE, BUSY.
- IDLE:
  - out_valid=0, ack=0, grant=0.
  - If req!=0, pick the first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
  - Next edge: grant=onehot(i), sel=i, cnt=0, state=BUSY.
  - Arbitration latency is 1 cycle, from req seen in IDLE to grant visible.
- BUSY:
  - out_data = lane sel, combinational through the 4:1 path.
  - out_valid = req[sel].
  - Accept = out_valid & out_ready.
  - ack[sel] = accept, combinational and same cycle. All other ack bits are 0.
  - On accept: cnt=cnt+1.
- BUSY exit: return to IDLE at the next edge if either:
  - (a) accept and cnt==MAX_BURST-1 (burst limit), or
  - (b) req[sel]==0 (requester done or aborted; no ack issued).
- On exit:
  - ptr=(sel+1) mod 4, grant=0, cnt=0.
  - sel holds its last value.
- Fairness:
  - A requester cannot win twice in a row while another requester is requesting.
  - Maximum wait for any requester is 3 bursts plus 3 arbitration cycles.
- Back-to-back bursts: at least one IDLE cycle always separates grants; there is no same-cycle handover.
- Simultaneous events:
  - A new req arriving during BUSY is ignored until IDLE.
  - req[sel] dropping in the same cycle out_ready=1 produces no accept, because out_valid is already 0.
- MAX_BURST=1: every grant carries exactly one beat.
- cnt width: 4 bits; cnt never exceeds MAX_BURST-1.
- out_ready low stalls indefinitely in BUSY. The grant is held and data must stay stable.
- X/unused: out_data in IDLE is lane sel. Consumers must qualify it with out_valid.

Test Plan:
1. Reset, then req=4'b0001 with din lane0=8'hA0 held and out_ready=1 for 6 cycles:
   - grant=0001, sel=0 one cycle after req.
   - 4 acks on lane0.
   - IDLE for 1 cycle, then re-grant to lane0 (only requester); ptr=1 after the first burst.
2. req=4'b1111 continuous, out_ready=1 from reset:
   - Grant order is lane0, lane1, lane2, lane3, lane0.
   - Each grant gives exactly 4 acks.
   - busy is low for exactly 1 cycle between bursts.
3. Grant lane2 (req=4'b0100), out_ready=0 for 5 cycles, then 1:
   - out_valid=1 and ack=0 during the stall.
   - grant=0100 held throughout.
   - Acks resume when out_ready rises.
4. Grant lane1, then drop req[1] after 2 accepted beats:
   - Exactly 2 acks.
   - IDLE next cycle, ptr=2.
   - With req=4'b0011 pending, next grant is lane0 (scan 2, 3, 0).
5. Assert rst for 1 cycle after 2 beats of a burst on lane3:
   - Next cycle grant=0, sel=0, out_valid=0, ptr=0.
   - With req=4'b1000 still high, re-grant to lane3 one cycle after rst falls.
6. MAX_BURST=1, req=4'b0101, out_ready=1:
   - Grants alternate lane0, lane2, lane0.
   - One ack per grant, each grant followed by 1 IDLE cycle.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 select path. A grant is held for a burst of up to
// MAX_BURST accepted beats, and the selected lane is presented on a valid/ready output.

module mux4_rr_lane #(
  parameter int WIDTH = 8
) (
  input  logic             selected,
  input  logic             active,
  input  logic             req,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] din,
  output logic             vld,
  output logic             ack,
  output logic [WIDTH-1:0] dout
);
  assign vld  = selected & active & req;
  assign ack  = vld & out_ready;
  assign dout = selected ? din : '0;
endmodule

module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [3:0]         ack,
  output logic [3:0]         grant,
  output logic [1:0]         sel,
  output logic               busy
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

  state_t     state, state_nx;
  logic [3:0] grant_nx;
  logic [1:0] sel_nx, ptr, ptr_nx, pick, idx;
  logic [3:0] cnt, cnt_nx;
  logic       found, accept;

  logic [3:0]            lane_vld;
  logic [3:0][WIDTH-1:0] lane_dout;

  // ack and out_valid are suppressed while rst is high so a beat never
  // completes in the cycle that abandons its burst.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    mux4_rr_lane #(.WIDTH(WIDTH)) u_lane (
      .selected (sel == 2'(i)),
      .active   ((state == BUSY) & ~rst),
      .req      (req[i]),
      .out_ready(out_ready),
      .din      (din[i*WIDTH +: WIDTH]),
      .vld      (lane_vld[i]),
      .ack      (ack[i]),
      .dout     (lane_dout[i])
    );
  end

  assign out_valid = |lane_vld;
  assign accept    = out_valid & out_ready;
  assign busy      = (state == BUSY);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < 4; i++) out_data |= lane_dout[i];
  end

  // First requester at or after ptr, wrapping mod 4.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    sel_nx   = sel;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = BUSY;
          grant_nx = 4'b0001 << pick;
          sel_nx   = pick;
          cnt_nx   = '0;
        end
      end
      BUSY: begin
        if (!req[sel] || (accept && cnt == LAST)) begin
          state_nx = IDLE;
          grant_nx = '0;
          cnt_nx   = '0;
          ptr_nx   = sel + 2'd1;
        end else if (accept) begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      sel   <= sel_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Cycle-by-cycle vector table for the round-robin arbiter; a second instance with
// MAX_BURST=1 shares the stimulus and is checked only on rows marked for it.

module tb_mux4_rr_arbiter;
  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         req = '0;
  logic [4*WIDTH-1:0] din = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
  logic               out_ready = 1'b1;

  logic             vld4, vld1, busy4, busy1;
  logic [WIDTH-1:0] data4, data1;
  logic [3:0]       ack4, ack1, grant4, grant1;
  logic [1:0]       sel4, sel1;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
    .out_valid(vld4), .out_data(data4), .ack(ack4), .grant(grant4),
    .sel(sel4), .busy(busy4)
  );

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
    .out_valid(vld1), .out_data(data1), .ack(ack1), .grant(grant1),
    .sel(sel1), .busy(busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [3:0] ack;
    logic       vld;
    logic       busy;
    logic       u;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  logic [WIDTH-1:0] lanes [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  int nvec = 0;
  int nerr = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic rd,
                     input logic [3:0] g, input logic [1:0] s, input logic [3:0] a,
                     input logic v, input logic b, input logic u);
    vec_t e;
    e.rst = r; e.req = rq; e.rdy = rd; e.grant = g; e.sel = s;
    e.ack = a; e.vld = v; e.busy = b; e.u = u;
    tbl.push_back(e);
  endtask

  task automatic chk(input int row, input string name, input int act, input int exp);
    if (act != exp) begin
      nerr++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  initial begin
    // reset state
    add(1, 4'h0, 1, 4'h0, 0, 4'h0, 0, 0, 0);
    // single requester lane0: 4-beat burst, 1 idle, re-grant, then drop
    add(0, 4'h1, 1, 4'h0, 0, 4'h0, 0, 0, 0);
    repeat (4) add(0, 4'h1, 1, 4'h1, 0, 4'h1, 1, 1, 0);
    add(0, 4'h1, 1, 4'h0, 0, 4'h0, 0, 0, 0);
    add(0, 4'h1, 1, 4'h1, 0, 4'h1, 1, 1, 0);
    add(0, 4'h0, 1, 4'h1, 0, 4'h0, 0, 1, 0);
    add(0, 4'h0, 1, 4'h0, 0, 4'h0, 0, 0, 0);
    // all four requesting: rotation 0,1,2,3,0
    add(1, 4'hF, 1, 4'h0, 0, 4'h0, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      add(0, 4'hF, 1, 4'h0, 2'(b == 0 ? 0 : b - 1), 4'h0, 0, 0, 0);
      repeat (4) add(0, 4'hF, 1, 4'(1 << b), 2'(b), 4'(1 << b), 1, 1, 0);
    end
    add(0, 4'hF, 1, 4'h0, 3, 4'h0, 0, 0, 0);
    add(0, 4'hF, 1, 4'h1, 0, 4'h1, 1, 1, 0);
    // reset mid-burst, then lane2 stalled for 5 cycles
    add(1, 4'h0, 1, 4'h1, 0, 4'h0, 0, 1, 0);
    add(0, 4'h4, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    repeat (5) add(0, 4'h4, 0, 4'h4, 2, 4'h0, 1, 1, 0);
    repeat (4) add(0, 4'h4, 1, 4'h4, 2, 4'h4, 1, 1, 0);
    add(0, 4'h0, 1, 4'h0, 2, 4'h0, 0, 0, 0);
    // lane1 aborts after 2 beats; ptr=2 so lane0 beats lane1
    add(0, 4'h2, 1, 4'h0, 2, 4'h0, 0, 0, 0);
    repeat (2) add(0, 4'h2, 1, 4'h2, 1, 4'h2, 1, 1, 0);
    add(0, 4'h1, 1, 4'h2, 1, 4'h0, 0, 1, 0);
    add(0, 4'h3, 1, 4'h0, 1, 4'h0, 0, 0, 0);
    add(0, 4'h3, 1, 4'h1, 0, 4'h1, 1, 1, 0);
    // lane3 burst cut by reset after 2 beats
    add(0, 4'h0, 1, 4'h1, 0, 4'h0, 0, 1, 0);
    add(0, 4'h8, 1, 4'h0, 0, 4'h0, 0, 0, 0);
    repeat (2) add(0, 4'h8, 1, 4'h8, 3, 4'h8, 1, 1, 0);
    add(1, 4'h8, 1, 4'h8, 3, 4'h0, 0, 1, 0);
    add(0, 4'h8, 1, 4'h0, 0, 4'h0, 0, 0, 0);
    add(0, 4'h8, 1, 4'h8, 3, 4'h8, 1, 1, 0);
    // MAX_BURST=1 instance: lanes 0 and 2 alternate, one beat each
    add(1, 4'h0, 1, 4'h8, 3, 4'h0, 0, 1, 0);
    add(0, 4'h5, 1, 4'h0, 0, 4'h0, 0, 0, 1);
    add(0, 4'h5, 1, 4'h1, 0, 4'h1, 1, 1, 1);
    add(0, 4'h5, 1, 4'h0, 0, 4'h0, 0, 0, 1);
    add(0, 4'h5, 1, 4'h4, 2, 4'h4, 1, 1, 1);
    add(0, 4'h5, 1, 4'h0, 2, 4'h0, 0, 0, 1);
    add(0, 4'h5, 1, 4'h1, 0, 4'h1, 1, 1, 1);
    add(0, 4'h0, 1, 4'h0, 0, 4'h0, 0, 0, 1);

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      @(posedge clk);
      #1;
      rst       = tbl[i].rst;
      req       = tbl[i].req;
      out_ready = tbl[i].rdy;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      nvec++;
      if (e.u) begin
        chk(i, "grant1", grant1, e.grant);
        chk(i, "sel1",   sel1,   e.sel);
        chk(i, "ack1",   ack1,   e.ack);
        chk(i, "valid1", vld1,   e.vld);
        chk(i, "busy1",  busy1,  e.busy);
        chk(i, "data1",  data1,  lanes[e.sel]);
      end else begin
        chk(i, "grant", grant4, e.grant);
        chk(i, "sel",   sel4,   e.sel);
        chk(i, "ack",   ack4,   e.ack);
        chk(i, "valid", vld4,   e.vld);
        chk(i, "busy",  busy4,  e.busy);
        chk(i, "data",  data4,  lanes[e.sel]);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
